reg_alu_pipe: RTL and testbench

Parametrised register file fused with a registered ALU stage. It is the successor to the fixed 2R/1W register-file-plus-adder pairing. Each accepted operation reads two registers, computes ADD/SUB/AND/OR and registers the result with flags. On output handshake it optionally writes the result back to a destination register. It has valid/ready flow control, result forwarding and a retired-op counter, and sits between the decode logic and the writeback/bus side of the datapath.

---
 rtl/reg_alu_pipe_if.sv | 35 +++
 rtl/reg_alu_pipe.sv | 119 +++++++++++
 tb/tb_reg_alu_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_alu_pipe_if.sv
// rtl/reg_alu_pipe_if.sv - operation, result and external-write bus for reg_alu_pipe
interface reg_alu_pipe_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5,
    parameter int CNT_WIDTH     = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [REG_NUM_WIDTH-1:0] rd_num_a;
    logic [REG_NUM_WIDTH-1:0] rd_num_b;
    logic [1:0]               op;
    logic [REG_NUM_WIDTH-1:0] dst_num;
    logic                     wb_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_carry;
    logic                     out_zero;
    logic                     ext_wr_en;
    logic [REG_NUM_WIDTH-1:0] ext_wr_num;
    logic [DATA_WIDTH-1:0]    ext_wr_data;
    logic [CNT_WIDTH-1:0]     retired_cnt;

    modport master (
        output in_valid, rd_num_a, rd_num_b, op, dst_num, wb_en,
        output out_ready, ext_wr_en, ext_wr_num, ext_wr_data,
        input  in_ready, out_valid, out_data, out_carry, out_zero, retired_cnt
    );

    modport slave (
        input  in_valid, rd_num_a, rd_num_b, op, dst_num, wb_en,
        input  out_ready, ext_wr_en, ext_wr_num, ext_wr_data,
        output in_ready, out_valid, out_data, out_carry, out_zero, retired_cnt
    );
endinterface

// File: rtl/reg_alu_pipe.sv
// rtl/reg_alu_pipe.sv - register file fused with a registered ALU stage, forwarding and writeback
module reg_alu_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM       = 32,
    parameter int REG_NUM_WIDTH = $clog2(REG_NUM),
    parameter int ZERO_REG      = 1,
    parameter int CNT_WIDTH     = 16
) (
    input logic           clk,
    input logic           rst_n,
    reg_alu_pipe_if.slave bus
);
    logic [DATA_WIDTH-1:0]    regFile [REG_NUM];

    logic                     outValid;
    logic [DATA_WIDTH-1:0]    outData;
    logic                     outCarry;
    logic                     outZero;
    logic [REG_NUM_WIDTH-1:0] pendDst;
    logic                     pendWb;
    logic [CNT_WIDTH-1:0]     retiredCnt;

    logic                     inReady;
    logic                     accept;
    logic                     retire;
    logic [DATA_WIDTH-1:0]    opA;
    logic [DATA_WIDTH-1:0]    opB;
    logic [DATA_WIDTH:0]      aluRes;

    assign inReady = !outValid || bus.out_ready;
    assign accept  = bus.in_valid && inReady;
    assign retire  = outValid && bus.out_ready;

    // Register 0 is hard-wired to zero when ZERO_REG is set
    function automatic logic isZeroReg(input logic [REG_NUM_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Zero register, then pending result, then same-cycle external write, then the array
    function automatic logic [DATA_WIDTH-1:0] readOperand(
        input logic [REG_NUM_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0]    arrVal
    );
        if (isZeroReg(idx))
            return '0;
        else if (outValid && pendWb && (pendDst == idx))
            return outData;
        else if (bus.ext_wr_en && (bus.ext_wr_num == idx))
            return bus.ext_wr_data;
        else
            return arrVal;
    endfunction

    // Operand fetch for both sources
    always_comb begin
        opA = readOperand(bus.rd_num_a, regFile[bus.rd_num_a]);
        opB = readOperand(bus.rd_num_b, regFile[bus.rd_num_b]);
    end

    // ALU: {carry, result}; SUB carry is the no-borrow flag
    always_comb begin
        aluRes = '0;
        case (bus.op)
            2'b00:   aluRes = {1'b0, opA} + {1'b0, opB};
            2'b01:   aluRes = {1'b0, opA} + {1'b0, ~opB} + {{DATA_WIDTH{1'b0}}, 1'b1};
            2'b10:   aluRes = {1'b0, opA & opB};
            default: aluRes = {1'b0, opA | opB};
        endcase
    end

    // Result register: load on accept, drain on retire, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outData  <= '0;
            outCarry <= 1'b0;
            outZero  <= 1'b0;
            pendDst  <= '0;
            pendWb   <= 1'b0;
        end else if (accept) begin
            outValid <= 1'b1;
            outData  <= aluRes[DATA_WIDTH-1:0];
            outCarry <= aluRes[DATA_WIDTH];
            outZero  <= (aluRes[DATA_WIDTH-1:0] == '0);
            pendDst  <= bus.dst_num;
            pendWb   <= bus.wb_en;
        end else if (retire) begin
            outValid <= 1'b0;
        end
    end

    // Retired-op counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retiredCnt <= '0;
        else if (retire)
            retiredCnt <= retiredCnt + 1'b1;
    end

    // Array writes; pipeline writeback is issued last so it wins a same-register collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++)
                regFile[i] <= '0;
        end else begin
            if (bus.ext_wr_en && !isZeroReg(bus.ext_wr_num))
                regFile[bus.ext_wr_num] <= bus.ext_wr_data;
            if (retire && pendWb && !isZeroReg(pendDst))
                regFile[pendDst] <= outData;
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.out_data    = outData;
    assign bus.out_carry   = outCarry;
    assign bus.out_zero    = outZero;
    assign bus.retired_cnt = retiredCnt;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb/tb_reg_alu_pipe.sv - directed self-checking bench for reg_alu_pipe
module tb_reg_alu_pipe;
    localparam int DW  = 32;
    localparam int RNW = 5;
    localparam int CW  = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   failCount;

    reg_alu_pipe_if #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RNW), .CNT_WIDTH(CW)) bus ();

    reg_alu_pipe #(
        .DATA_WIDTH(DW), .REG_NUM(32), .REG_NUM_WIDTH(RNW), .ZERO_REG(1), .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic extWrite(input logic [RNW-1:0] num, input logic [DW-1:0] data);
        bus.ext_wr_en   = 1'b1;
        bus.ext_wr_num  = num;
        bus.ext_wr_data = data;
        step();
        bus.ext_wr_en   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [RNW-1:0] a, input logic [RNW-1:0] b,
                         input logic [RNW-1:0] dst, input logic wb);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rd_num_a = a;
        bus.rd_num_b = b;
        bus.dst_num  = dst;
        bus.wb_en    = wb;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [DW-1:0] data,
                               input logic carry, input logic zero);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"},  64'(bus.out_data),  64'(data));
        check({tag, "_carry"}, 64'(bus.out_carry), 64'(carry));
        check({tag, "_zero"},  64'(bus.out_zero),  64'(zero));
    endtask

    initial begin
        testsRun        = 0;
        failCount       = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.rd_num_a    = '0;
        bus.rd_num_b    = '0;
        bus.op          = OP_ADD;
        bus.dst_num     = '0;
        bus.wb_en       = 1'b0;
        bus.out_ready   = 1'b1;
        bus.ext_wr_en   = 1'b0;
        bus.ext_wr_num  = '0;
        bus.ext_wr_data = '0;

        #2;
        check("rst_valid", 64'(bus.out_valid),   64'd0);
        check("rst_data",  64'(bus.out_data),    64'd0);
        check("rst_cnt",   64'(bus.retired_cnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // ADD r1+r2 = 5+7
        extWrite(5'd1, 32'd5);
        extWrite(5'd2, 32'd7);
        issue(OP_ADD, 5'd1, 5'd2, 5'd0, 1'b0);
        checkResult("add", 32'd12, 1'b0, 1'b0);
        check("add_cnt_before", 64'(bus.retired_cnt), 64'd0);
        step();
        check("add_drain_valid", 64'(bus.out_valid),   64'd0);
        check("add_cnt_after",   64'(bus.retired_cnt), 64'd1);

        // SUB with borrow, then back-to-back SUB to zero
        extWrite(5'd1, 32'd3);
        extWrite(5'd2, 32'd5);
        issue(OP_SUB, 5'd1, 5'd2, 5'd0, 1'b0);
        checkResult("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(OP_SUB, 5'd1, 5'd1, 5'd0, 1'b0);
        checkResult("sub_zero", 32'd0, 1'b1, 1'b1);
        step();
        check("sub_cnt", 64'(bus.retired_cnt), 64'd3);

        // ADD overflow wraps with carry
        extWrite(5'd1, 32'hFFFF_FFFF);
        extWrite(5'd2, 32'd1);
        issue(OP_ADD, 5'd1, 5'd2, 5'd0, 1'b0);
        checkResult("add_ovf", 32'd0, 1'b1, 1'b1);
        step();

        // AND of 0xFFFFFFFF with 1
        issue(OP_AND, 5'd1, 5'd2, 5'd0, 1'b0);
        checkResult("and", 32'd1, 1'b0, 1'b0);
        step();
        check("and_cnt", 64'(bus.retired_cnt), 64'd5);

        // Forwarding: r3 = r1+r1 = 20, then r4 = r3+r1 = 30 back to back
        extWrite(5'd1, 32'd10);
        issue(OP_ADD, 5'd1, 5'd1, 5'd3, 1'b1);
        checkResult("fwd_r3", 32'd20, 1'b0, 1'b0);
        issue(OP_ADD, 5'd3, 5'd1, 5'd4, 1'b1);
        checkResult("fwd_r4", 32'd30, 1'b0, 1'b0);
        step();
        issue(OP_OR, 5'd4, 5'd0, 5'd0, 1'b0);
        checkResult("rd_r4", 32'd30, 1'b0, 1'b0);
        step();
        check("fwd_cnt", 64'(bus.retired_cnt), 64'd8);

        // Backpressure: result held, request held but not taken
        bus.out_ready = 1'b0;
        issue(OP_ADD, 5'd1, 5'd1, 5'd5, 1'b1);
        checkResult("bp_load", 32'd20, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.op       = OP_OR;
        bus.rd_num_a = 5'd4;
        bus.rd_num_b = 5'd4;
        bus.dst_num  = 5'd6;
        bus.wb_en    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            step();
            check("bp_data", 64'(bus.out_data),    64'd20);
            check("bp_cnt",  64'(bus.retired_cnt), 64'd8);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(bus.out_valid),   64'd0);
        check("bp_release_cnt",   64'(bus.retired_cnt), 64'd9);
        issue(OP_OR, 5'd5, 5'd0, 5'd0, 1'b0);
        checkResult("rd_r5", 32'd20, 1'b0, 1'b0);
        step();

        // Zero register ignores writes
        extWrite(5'd0, 32'd9);
        issue(OP_OR, 5'd0, 5'd0, 5'd0, 1'b0);
        checkResult("rd_r0", 32'd0, 1'b0, 1'b1);
        step();

        // Same-cycle external write is bypassed to the operand
        bus.ext_wr_en   = 1'b1;
        bus.ext_wr_num  = 5'd7;
        bus.ext_wr_data = 32'h55;
        issue(OP_OR, 5'd7, 5'd0, 5'd0, 1'b0);
        bus.ext_wr_en   = 1'b0;
        checkResult("ext_bypass", 32'h55, 1'b0, 1'b0);
        step();

        // Collision: retire writeback r5=2 beats ext write r5=1
        extWrite(5'd6, 32'd2);
        issue(OP_OR, 5'd6, 5'd0, 5'd5, 1'b1);
        checkResult("coll_load", 32'd2, 1'b0, 1'b0);
        extWrite(5'd5, 32'd1);
        issue(OP_OR, 5'd5, 5'd0, 5'd0, 1'b0);
        checkResult("coll_r5", 32'd2, 1'b0, 1'b0);
        step();
        check("coll_cnt", 64'(bus.retired_cnt), 64'd14);

        // Async reset with a pending writeback result
        bus.out_ready = 1'b0;
        issue(OP_ADD, 5'd1, 5'd1, 5'd8, 1'b1);
        checkResult("rst_pend", 32'd20, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid),   64'd0);
        check("arst_data",  64'(bus.out_data),    64'd0);
        check("arst_cnt",   64'(bus.retired_cnt), 64'd0);
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        issue(OP_OR, 5'd8, 5'd1, 5'd0, 1'b0);
        checkResult("arst_r8", 32'd0, 1'b0, 1'b1);
        step();
        check("arst_cnt_after", 64'(bus.retired_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
